// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI single-port RAM subsystem: FSM states,
// command encodings and default word widths.
package spi_ram_pkg;

    localparam int DEF_RX_W = 10;
    localparam int DEF_TX_W = 8;

    // Upper two bits of every received word; cmd[1] doubles as the routing bit.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    function automatic logic is_shift_state(input state_t s);
        return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
    endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Loads one read-data byte and shifts it out MSB-first on MISO, one bit per clk.
// MISO is held at 0 whenever no byte is being sent.
module spi_tx_serializer #(
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic [TX_W-1:0] i_data,
    output logic            o_miso,
    output logic            o_busy
);

    localparam int CNT_W = (TX_W > 1) ? $clog2(TX_W) : 1;

    logic [TX_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_bits_left;
    logic             r_miso;
    logic             r_busy;

    // The MSB goes straight onto MISO at load, so the first bit appears
    // the cycle after i_load without any extra pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_bits_left <= '0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
        end else if (i_clear) begin
            r_shift     <= '0;
            r_bits_left <= '0;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
        end else if (i_load) begin
            r_miso      <= i_data[TX_W-1];
            r_shift     <= {i_data[TX_W-2:0], 1'b0};
            r_bits_left <= CNT_W'(TX_W - 1);
            r_busy      <= 1'b1;
        end else if (r_busy) begin
            if (r_bits_left != '0) begin
                r_miso      <= r_shift[TX_W-1];
                r_shift     <= {r_shift[TX_W-2:0], 1'b0};
                r_bits_left <= r_bits_left - 1'b1;
            end else begin
                r_miso <= 1'b0;
                r_busy <= 1'b0;
            end
        end
    end

    assign o_miso = r_miso;
    assign o_busy = r_busy;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: routes each frame on its first MOSI bit, deserialises
// the following word for the RAM and returns read data on MISO.
module spi_slave_if
    import spi_ram_pkg::*;
#(
    parameter int RX_W = DEF_RX_W,
    parameter int TX_W = DEF_TX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam int CNT_W = $clog2(RX_W + 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [RX_W-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [RX_W-1:0] r_rx_data;
    logic            r_rx_valid;
    logic            r_rd_addr_done;
    logic            r_wait_tx;

    logic            w_shifting;
    logic            w_last_bit;
    logic            w_tx_load;
    logic            w_tx_busy;
    logic            w_miso;

    // Once the counter reaches RX_W the frame is done; further MOSI bits are dropped.
    assign w_shifting = is_shift_state(r_state) && !SS_n && (r_bit_cnt < CNT_W'(RX_W));
    assign w_last_bit = w_shifting && (r_bit_cnt == CNT_W'(RX_W - 1));
    assign w_tx_load  = tx_valid && r_wait_tx && !w_tx_busy && !SS_n && (r_state == READ_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (!SS_n) w_state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)                 w_state_next = IDLE;
                else if (!MOSI)           w_state_next = WRITE;
                else if (r_rd_addr_done)  w_state_next = READ_DATA;
                else                      w_state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_done <= 1'b0;
            r_wait_tx      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (SS_n) begin
                r_bit_cnt <= '0;
                r_wait_tx <= 1'b0;
            end else if (w_shifting) begin
                r_shift   <= {r_shift[RX_W-2:0], MOSI};
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_last_bit) begin
                    r_rx_data  <= {r_shift[RX_W-2:0], MOSI};
                    r_rx_valid <= 1'b1;
                    // The routing state, not the received cmd bits, drives the read-address flag.
                    if (r_state == READ_ADD) begin
                        r_rd_addr_done <= 1'b1;
                    end
                    if (r_state == READ_DATA) begin
                        r_rd_addr_done <= 1'b0;
                        r_wait_tx      <= 1'b1;
                    end
                end
            end else if (w_tx_load) begin
                r_wait_tx <= 1'b0;
            end
        end
    end

    spi_tx_serializer #(
        .TX_W (TX_W)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_clear (SS_n),
        .i_load  (w_tx_load),
        .i_data  (tx_data),
        .o_miso  (w_miso),
        .o_busy  (w_tx_busy)
    );

    assign MISO     = w_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end of the SPI single-port RAM subsystem; sits directly upstream of the RAM block.
- Deserialises MOSI frames into 10-bit command/data words and presents them on rx_data with a one-cycle rx_valid pulse.
- Captures the RAM's 8-bit read data on tx_valid and serialises it MSB-first on MISO.
- Tracks whether a read address has been loaded, and uses that to route read frames.

Parameters:
- RX_W, 10, width of the word delivered to the RAM: 2 command bits plus 8 address/data bits.
- TX_W, 8, width of the read data returned by the RAM.

Ports:
- clk  in  1  system clock, also the SPI bit clock; all sampling is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  slave select, active low; frames the transaction.
- MOSI  in  1  serial data from the master, MSB first.
- MISO  out  1  serial read data to the master, MSB first.
- rx_data  out  RX_W  assembled word to the RAM: {cmd[1:0], payload[7:0]}.
- rx_valid  out  1  one-cycle pulse; rx_data is stable while it is high.
- tx_data  in  TX_W  read data from the RAM.
- tx_valid  in  1  qualifies tx_data (single-cycle pulse).

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE; MISO=0; rx_data=0; rx_valid=0.
  - rd_addr_done=0; bit counter=0; tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - SS_n sampled 0 -> CHK_CMD.
  - Otherwise stay in IDLE.
- CHK_CMD: samples MOSI as the routing bit (the frame's first bit, equal to cmd[1]). Next state:
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_done=0 -> READ_ADD.
  - MOSI=1 and rd_addr_done=1 -> READ_DATA.
- WRITE, READ_ADD and READ_DATA all shift in RX_W bits from MOSI, MSB first, one per clk, into the internal shift register.
- Frame format: 1 routing bit followed by a 10-bit word, so 11 MOSI bits in total. The routing bit is not stored.
- rx_valid timing:
  - rx_data updates and rx_valid=1 on the cycle after the 10th word bit is sampled.
  - rx_valid is cleared the following cycle.
  - Only one pulse is issued per frame.
- The word is forwarded as shifted in. A routing bit that mismatches cmd[1] is not checked; the routing state still governs the rd_addr_done update.
- rd_addr_done:
  - Set on rx_valid of a completed READ_ADD frame.
  - Cleared on rx_valid of a completed READ_DATA frame.
  - Unchanged by WRITE frames.
- READ_DATA read-back:
  - After rx_valid the block waits for tx_valid.
  - On tx_valid it loads tx_data into the TX shift register.
  - Starting the next cycle, MISO drives tx_data[7] down to tx_data[0], one bit per clk, 8 cycles in total.
  - MISO returns to 0 after the 8th bit.
- tx_valid received in any state other than a READ_DATA frame awaiting data is ignored.
- SS_n rising at any point (mid-shift, mid-read-back):
  - Next state is IDLE.
  - Counter cleared, MISO=0.
  - No rx_valid is emitted for a partial word.
  - rd_addr_done is unchanged.
- SS_n held low after frame completion: the block stays in its state with no further rx_valid. Extra MOSI bits are ignored.
- MISO=0 whenever the block is not serialising read data.
- rst asserted mid-frame: all state is returned to reset values immediately.

Decomposition:
- Shared package spi_ram_pkg holds:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - command localparams: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - RX_W and TX_W defaults.
- One natural sub-module: spi_tx_serializer (load on tx_valid, 8-bit MSB-first shift, busy flag, MISO output).
- The FSM and RX shifter stay in spi_slave_if.

Test Plan:
- Write-address frame: SS_n low, MOSI 0 then 00_1010_0101 -> rx_data=10'h0A5, single rx_valid pulse 1 cycle after the last bit; rd_addr_done stays 0.
- Write-data frame: routing 0, word 01_0011_1100 -> rx_data=10'h13C, rx_valid pulse; then SS_n high -> IDLE.
- Read-address then read-data:
  - Frame 1: routing 1, word 10_0000_0111 -> rx_data=10'h207, rd_addr_done=1.
  - Frame 2: routing 1, word 11_xxxx_xxxx -> state READ_DATA, rx_valid pulse.
  - Drive tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on the 8 following cycles; rd_addr_done=0 afterwards.
- Abort: SS_n high after 5 word bits -> no rx_valid, state IDLE next cycle. A following full frame is decoded correctly.
- Async reset mid read-back: assert rst during MISO bit 3 -> MISO=0, rx_valid=0, state IDLE, rd_addr_done=0 immediately.
- Stray tx_valid during a WRITE frame -> MISO stays 0; the frame completes normally.
